mmio_bridge: RTL and testbench

Memory-mapped I/O bridge directly downstream of the single-cycle core's data port (`mem_write`, `alu_result`, `write_data`, `read_data`). It decodes each data access:

- Addresses below the MMIO base pass through to data RAM.
- Addresses in a 256-byte MMIO window reach a small register file. The window holds a free-running cycle counter, a compare/match timer, a GPIO output register, and a transmit FIFO with a valid/ready streaming output.

Reads are combinational so the core keeps single-cycle loads. Writes commit on the clock edge.

---
 rtl/mmio_pkg.sv | 35 +++
 rtl/tx_fifo.sv | 80 ++++++++
 rtl/mmio_bridge.sv | 158 +++++++++++++++
 tb/tb_mmio_bridge.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_pkg
// Description : Shared constants for the MMIO bridge: register word offsets
//               (addr[7:2]), status bit positions, and the TIMER_CMP reset
//               value.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_pkg;

    // Register word offsets, selected by addr[7:2]
    localparam logic [5:0] c_REG_CYCLE     = 6'h00;  // 0x00
    localparam logic [5:0] c_REG_GPIO      = 6'h01;  // 0x04
    localparam logic [5:0] c_REG_TX_DATA   = 6'h02;  // 0x08
    localparam logic [5:0] c_REG_TX_STATUS = 6'h03;  // 0x0C
    localparam logic [5:0] c_REG_TIMER_CMP = 6'h04;  // 0x10
    localparam logic [5:0] c_REG_TIMER_STS = 6'h05;  // 0x14

    // TX_STATUS bit positions
    localparam int c_STAT_EMPTY_BIT = 0;
    localparam int c_STAT_FULL_BIT  = 1;
    localparam int c_STAT_OVF_BIT   = 2;
    localparam int c_STAT_COUNT_LSB = 8;

    // TIMER_STATUS bit positions
    localparam int c_TSTAT_MATCH_BIT = 0;

    // Compare value that the counter only reaches after a full wrap
    localparam logic [31:0] c_TIMER_CMP_RST = 32'hFFFF_FFFF;

    // Size of the MMIO window in bytes
    localparam logic [31:0] c_WINDOW_BYTES = 32'd256;

endpackage : mmio_pkg
`default_nettype wire

// File: rtl/tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tx_fifo
// Description : Circular-buffer FIFO. Pushes while full and pops while empty
//               are ignored; the caller decides what a refused push means.
//               The head output is forced to zero when the FIFO is empty.
// Ports       : clk_i   - clock
//               rst_i   - asynchronous active-low reset
//               push_i  - write data_i at the tail
//               pop_i   - discard the head entry
//               data_i  - entry to push
//               data_o  - head entry (0 when empty)
//               full_o  - all entries occupied
//               empty_o - no entries occupied
//               count_o - occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL_COUNT = (c_AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full_o    = (r_count == c_FULL_COUNT);
    assign empty_o   = (r_count == '0);
    assign count_o   = r_count;
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;
    // Gating keeps stale or never-written storage off the output
    assign data_o    = empty_o ? '0 : r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage is not reset; empty_o masks its contents
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

endmodule : tx_fifo
`default_nettype wire

// File: rtl/mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mmio_bridge
// Description : Data-port decoder for a single-cycle core. Addresses below
//               MMIO_BASE go to RAM; a 256-byte window at MMIO_BASE holds a
//               cycle counter, a compare timer, a GPIO register and a TX
//               FIFO with a valid/ready output. Reads are combinational,
//               writes commit on the rising edge.
// Ports       : clk_i, rst_i (async active-low)
//               mem_write_i, addr_i, write_data_i, read_data_o - core side
//               ram_we_o, ram_rdata_i                          - RAM side
//               gpio_o                                         - GPIO out
//               tx_data_o, tx_valid_o, tx_ready_i              - TX stream
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter int          GPIO_W     = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_1000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_write_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       write_data_i,
    output logic [31:0]       read_data_o,
    output logic              ram_we_o,
    input  logic [31:0]       ram_rdata_i,
    output logic [GPIO_W-1:0] gpio_o,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i
);

    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]        r_cycle;
    logic [GPIO_W-1:0]  r_gpio;
    logic [31:0]        r_timer_cmp;
    logic               r_match;
    logic               r_overflow;

    logic               w_is_ram;
    logic               w_is_mmio;
    logic [31:0]        w_win_off;
    logic [5:0]         w_reg;
    logic               w_mmio_wr;
    logic               w_push_req;
    logic               w_push;
    logic               w_drop;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [c_CNT_W-1:0] w_count;
    logic [31:0]        w_tx_status;
    logic [31:0]        w_mmio_rdata;

    // Subtracting first avoids wrap-around of MMIO_BASE + 0xFF
    assign w_is_ram   = (addr_i < MMIO_BASE);
    assign w_win_off  = addr_i - MMIO_BASE;
    assign w_is_mmio  = !w_is_ram && (w_win_off < c_WINDOW_BYTES);
    assign w_reg      = addr_i[7:2];
    assign w_mmio_wr  = mem_write_i && w_is_mmio;

    assign ram_we_o   = mem_write_i && w_is_ram;

    assign w_push_req = w_mmio_wr && (w_reg == c_REG_TX_DATA);
    // Full is judged on the pre-edge count, so a same-cycle pop never
    // makes room for the push.
    assign w_push     = w_push_req && !w_full;
    assign w_drop     = w_push_req && w_full;
    assign w_pop      = tx_valid_o && tx_ready_i;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .data_i  (write_data_i[7:0]),
        .data_o  (tx_data_o),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    assign tx_valid_o = !w_empty;
    assign gpio_o     = r_gpio;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cycle     <= '0;
            r_gpio      <= '0;
            r_timer_cmp <= c_TIMER_CMP_RST;
            r_match     <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 32'd1;

            if (w_mmio_wr && (w_reg == c_REG_GPIO)) begin
                r_gpio <= write_data_i[GPIO_W-1:0];
            end
            if (w_mmio_wr && (w_reg == c_REG_TIMER_CMP)) begin
                r_timer_cmp <= write_data_i;
            end

            // Sticky flags: a set event beats a coincident write-1-to-clear
            if (r_cycle == r_timer_cmp) begin
                r_match <= 1'b1;
            end else if (w_mmio_wr && (w_reg == c_REG_TIMER_STS)
                         && write_data_i[c_TSTAT_MATCH_BIT]) begin
                r_match <= 1'b0;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_mmio_wr && (w_reg == c_REG_TX_STATUS)
                         && write_data_i[c_STAT_OVF_BIT]) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        w_tx_status                                = '0;
        w_tx_status[c_STAT_EMPTY_BIT]              = w_empty;
        w_tx_status[c_STAT_FULL_BIT]               = w_full;
        w_tx_status[c_STAT_OVF_BIT]                = r_overflow;
        w_tx_status[c_STAT_COUNT_LSB +: 8]         = 8'(w_count);
    end

    always_comb begin
        w_mmio_rdata = '0;
        case (w_reg)
            c_REG_CYCLE:     w_mmio_rdata = r_cycle;
            c_REG_GPIO:      w_mmio_rdata[GPIO_W-1:0] = r_gpio;
            c_REG_TX_STATUS: w_mmio_rdata = w_tx_status;
            c_REG_TIMER_CMP: w_mmio_rdata = r_timer_cmp;
            c_REG_TIMER_STS: w_mmio_rdata[c_TSTAT_MATCH_BIT] = r_match;
            default:         w_mmio_rdata = '0;
        endcase
    end

    always_comb begin
        read_data_o = '0;
        if (w_is_ram) begin
            read_data_o = ram_rdata_i;
        end else if (w_is_mmio) begin
            read_data_o = w_mmio_rdata;
        end
    end

endmodule : mmio_bridge
`default_nettype wire

// File: tb/tb_mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_bridge
// Description : Self-checking bench for mmio_bridge. TX bytes are queued in
//               a scoreboard when written and compared as they leave the
//               stream port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_bridge;

    localparam logic [31:0] c_BASE      = 32'h0000_1000;
    localparam logic [31:0] c_A_CYCLE   = c_BASE + 32'h00;
    localparam logic [31:0] c_A_GPIO    = c_BASE + 32'h04;
    localparam logic [31:0] c_A_TXDATA  = c_BASE + 32'h08;
    localparam logic [31:0] c_A_TXSTAT  = c_BASE + 32'h0C;
    localparam logic [31:0] c_A_TCMP    = c_BASE + 32'h10;
    localparam logic [31:0] c_A_TSTAT   = c_BASE + 32'h14;
    localparam logic [31:0] c_RAM_DATA  = 32'hDEAD_BEEF;
    localparam int          c_DEPTH     = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ram_we;
    logic [31:0] ram_rdata = c_RAM_DATA;
    logic [7:0]  gpio;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  sb [$];
    logic [7:0]  m_exp;
    int unsigned tb_cyc;

    mmio_bridge #(
        .FIFO_DEPTH (c_DEPTH),
        .GPIO_W     (8),
        .MMIO_BASE  (c_BASE)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .mem_write_i  (mem_write),
        .addr_i       (addr),
        .write_data_i (wdata),
        .read_data_o  (rdata),
        .ram_we_o     (ram_we),
        .ram_rdata_i  (ram_rdata),
        .gpio_o       (gpio),
        .tx_data_o    (tx_data),
        .tx_valid_o   (tx_valid),
        .tx_ready_i   (tx_ready)
    );

    always #5 clk = ~clk;

    // Reference cycle count
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= 0;
        else        tb_cyc <= tb_cyc + 1;
    end

    // Stream monitor: inputs change on the falling edge, so 2 units later
    // the handshake that the next rising edge will take is settled.
    always @(negedge clk) begin
        #2;
        if (rst_n && tx_valid && tx_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL tx_extra got=%02h expected=none", tx_data);
            end else begin
                m_exp = sb.pop_front();
                if (tx_data !== m_exp) begin
                    n_errors++;
                    $display("FAIL tx_byte got=%02h expected=%02h", tx_data, m_exp);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "timeout");
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        mem_write = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_write = 1'b1;
        addr = a;
        wdata = d;
        @(negedge clk);
        mem_write = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        mem_write = 1'b0;
        addr = a;
        #1 d = rdata;
    endtask

    task automatic push_byte(input logic [7:0] b);
        if (sb.size() < c_DEPTH) sb.push_back(b);
        do_write(c_A_TXDATA, {24'h0, b});
    endtask

    task automatic drain(input string name);
        tx_ready = 1'b1;
        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        #3;
        n_checks++;
        if (sb.size() != 0 || tx_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_drain got left=%0d valid=%b expected left=0 valid=0",
                     name, sb.size(), tx_valid);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        mem_write = 1'b1;
        addr = 32'h0000_0100;
        #1;
        n_checks++;
        if (ram_we !== 1'b1) begin
            n_errors++; $display("FAIL reset_ram_we got=%b expected=1", ram_we);
        end
        mem_write = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        addr = c_A_CYCLE;
        #1 d = rdata;
        n_checks++;
        if (d !== 32'd5) begin
            n_errors++; $display("FAIL reset_cycle got=%08h expected=00000005", d);
        end
        addr = c_A_GPIO;
        #1 d = rdata;
        n_checks++;
        if (d !== 32'h0 || gpio !== 8'h0) begin
            n_errors++; $display("FAIL reset_gpio got=%08h/%02h expected=0", d, gpio);
        end
        addr = c_A_TXSTAT;
        #1 d = rdata;
        n_checks++;
        if (d !== 32'h0000_0001 || tx_valid !== 1'b0 || tx_data !== 8'h0) begin
            n_errors++;
            $display("FAIL reset_txstat got=%08h v=%b d=%02h expected=00000001 v=0 d=00",
                     d, tx_valid, tx_data);
        end
        addr = c_A_TCMP;
        #1 d = rdata;
        n_checks++;
        if (d !== 32'hFFFF_FFFF) begin
            n_errors++; $display("FAIL reset_tcmp got=%08h expected=ffffffff", d);
        end
        addr = c_A_TSTAT;
        #1 d = rdata;
        n_checks++;
        if (d !== 32'h0) begin
            n_errors++; $display("FAIL reset_tstat got=%08h expected=0", d);
        end
    endtask

    task automatic test_ram_gpio();
        logic [31:0] d;
        @(negedge clk);
        mem_write = 1'b1; addr = 32'h0000_0FFC; wdata = 32'hAB;
        #1;
        n_checks++;
        if (ram_we !== 1'b1 || rdata !== c_RAM_DATA) begin
            n_errors++;
            $display("FAIL ram_pass got we=%b rd=%08h expected we=1 rd=%08h", ram_we, rdata, c_RAM_DATA);
        end
        @(negedge clk);
        addr = c_A_GPIO; wdata = 32'hA5;
        #1;
        n_checks++;
        if (ram_we !== 1'b0) begin
            n_errors++; $display("FAIL gpio_ram_we got=%b expected=0", ram_we);
        end
        @(negedge clk);
        mem_write = 1'b0;
        do_read(c_A_GPIO, d);
        n_checks++;
        if (d !== 32'hA5 || gpio !== 8'hA5) begin
            n_errors++; $display("FAIL gpio_rw got=%08h/%02h expected=000000a5/a5", d, gpio);
        end
    endtask

    task automatic test_fifo_overflow();
        logic [31:0] d;
        tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) push_byte(8'(i));
        do_read(c_A_TXSTAT, d);
        n_checks++;
        if (d !== 32'h0000_0806) begin
            n_errors++; $display("FAIL ovf_full_status got=%08h expected=00000806", d);
        end
        drain("ovf");
        do_read(c_A_TXSTAT, d);
        n_checks++;
        if (d !== 32'h0000_0005) begin
            n_errors++; $display("FAIL ovf_sticky got=%08h expected=00000005", d);
        end
        do_write(c_A_TXSTAT, 32'h4);
        do_read(c_A_TXSTAT, d);
        n_checks++;
        if (d !== 32'h0000_0001) begin
            n_errors++; $display("FAIL ovf_w1c got=%08h expected=00000001", d);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] d;
        tx_ready = 1'b0;
        for (int i = 0; i < c_DEPTH; i++) push_byte(8'h10 + 8'(i));
        @(negedge clk);
        mem_write = 1'b1; addr = c_A_TXDATA; wdata = 32'h77;
        tx_ready = 1'b1;
        @(negedge clk);
        mem_write = 1'b0;
        tx_ready = 1'b0;
        do_read(c_A_TXSTAT, d);
        n_checks++;
        if (d !== 32'h0000_0704) begin
            n_errors++; $display("FAIL full_pushpop_status got=%08h expected=00000704", d);
        end
        drain("pushpop");
        do_write(c_A_TXSTAT, 32'h4);
        do_read(c_A_TXSTAT, d);
        n_checks++;
        if (d !== 32'h0000_0001) begin
            n_errors++; $display("FAIL pushpop_clear got=%08h expected=00000001", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        // Push and pop together while neither empty nor full
        tx_ready = 1'b0;
        push_byte(8'h31);
        push_byte(8'h32);
        @(negedge clk);
        sb.push_back(8'h33);
        mem_write = 1'b1; addr = c_A_TXDATA; wdata = 32'h33;
        tx_ready = 1'b1;
        @(negedge clk);
        mem_write = 1'b0;
        tx_ready = 1'b0;
        do_read(c_A_TXSTAT, d);
        n_checks++;
        if (d !== 32'h0000_0200) begin
            n_errors++; $display("FAIL b2b_status got=%08h expected=00000200", d);
        end
        drain("b2b");
    endtask

    task automatic test_timer();
        logic [31:0] d;
        int unsigned tgt;
        bit seen;
        apply_reset();
        do_write(c_A_TCMP, 32'd20);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            addr = c_A_CYCLE;
            #1 d = rdata;
            n_checks++;
            if (d !== 32'(tb_cyc)) begin
                n_errors++; $display("FAIL timer_cycle got=%0d expected=%0d", d, tb_cyc);
            end
            addr = c_A_TSTAT;
            #1 d = rdata;
            n_checks++;
            if (d !== {31'h0, (tb_cyc >= 21)}) begin
                n_errors++; $display("FAIL timer_match cyc=%0d got=%08h expected=%0d", tb_cyc, d, tb_cyc >= 21);
            end
            if (tb_cyc >= 23) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_errors++; $display("FAIL timer_reach got=no expected=cycle23");
        end
        do_write(c_A_TSTAT, 32'h1);
        do_read(c_A_TSTAT, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_errors++; $display("FAIL timer_w1c got=%08h expected=0", d);
        end
        tgt = tb_cyc + 8;
        do_write(c_A_TCMP, 32'(tgt));
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (tb_cyc == tgt) begin
                seen = 1'b1;
                mem_write = 1'b1; addr = c_A_TSTAT; wdata = 32'h1;
                @(negedge clk);
                mem_write = 1'b0;
                #1 d = rdata;
                n_checks++;
                if (d !== 32'h1) begin
                    n_errors++; $display("FAIL timer_set_wins got=%08h expected=1", d);
                end
            end
        end
        n_checks++;
        if (!seen) begin
            n_errors++; $display("FAIL timer_reach2 got=no expected=cycle%0d", tgt);
        end
        do_write(c_A_TSTAT, 32'h1);
        do_read(c_A_TSTAT, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_errors++; $display("FAIL timer_w1c2 got=%08h expected=0", d);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        do_write(c_A_GPIO, 32'h3C);
        do_read(c_BASE + 32'h18, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_errors++; $display("FAIL unmap_1018 got=%08h expected=0", d);
        end
        do_read(32'h0000_2000, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_errors++; $display("FAIL unmap_2000 got=%08h expected=0", d);
        end
        @(negedge clk);
        mem_write = 1'b1; addr = 32'h0000_2000; wdata = 32'hFF;
        #1;
        n_checks++;
        if (ram_we !== 1'b0) begin
            n_errors++; $display("FAIL unmap_ram_we got=%b expected=0", ram_we);
        end
        @(negedge clk);
        addr = c_BASE + 32'h104;  // aliases the GPIO offset outside the window
        @(negedge clk);
        addr = c_BASE + 32'h18;
        @(negedge clk);
        mem_write = 1'b0;
        do_read(c_A_GPIO, d);
        n_checks++;
        if (d !== 32'h3C || gpio !== 8'h3C) begin
            n_errors++; $display("FAIL unmap_nochange got=%08h/%02h expected=0000003c/3c", d, gpio);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        tx_ready = 1'b0;
        push_byte(8'h5A);
        @(negedge clk);
        #1;
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h5A) begin
            n_errors++; $display("FAIL arst_pre got v=%b d=%02h expected v=1 d=5a", tx_valid, tx_data);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h0 || gpio !== 8'h0) begin
            n_errors++;
            $display("FAIL arst_drop got v=%b d=%02h g=%02h expected v=0 d=00 g=00", tx_valid, tx_data, gpio);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        do_read(c_A_TXSTAT, d);
        n_checks++;
        if (d !== 32'h0000_0001) begin
            n_errors++; $display("FAIL arst_status got=%08h expected=00000001", d);
        end
    endtask

    initial begin
        test_reset();
        test_ram_gpio();
        test_fifo_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_timer();
        test_unmapped();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mmio_bridge
`default_nettype wire
